// File: rtl/spi_flash_responder.sv
// spi_flash_responder: mode-0 SPI target that behaves like a small serial NOR
// flash. The SPI pins are oversampled on clk_i. The block answers Read, Page
// Program, Read ID, Read Status, Write Enable and Write Disable.
module spi_flash_responder #(
  parameter int unsigned MemBytes = 256,
  parameter logic [23:0] JedecId  = 24'hEF4018
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_ni,
  input  logic       spi_copi_i,
  output logic       spi_cipo_o,
  output logic       spi_cipo_en_o,
  output logic [7:0] cmd_o,
  output logic       cmd_valid_o,
  output logic       wel_o
);
  localparam int unsigned AW = $clog2(MemBytes);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    READ   = 3'd3,
    PROG   = 3'd4,
    RESP   = 3'd5,
    IGNORE = 3'd6
  } state_t;

  // Change to the write-enable latch that is applied when CS_N rises.
  typedef enum logic [1:0] {
    WEL_KEEP = 2'd0,
    WEL_SET  = 2'd1,
    WEL_CLR  = 2'd2
  } wel_act_t;

  state_t        state_r, state_next;
  wel_act_t      wel_act_r;
  logic [2:0]    sck_sync_r, cs_sync_r;
  logic [1:0]    copi_sync_r;
  logic [2:0]    bit_cnt_r;
  logic [6:0]    shift_r;
  logic [1:0]    addr_cnt_r;
  logic [AW-2:0] addr_r;
  logic [AW-1:0] ptr_r;
  logic [7:0]    pending_r, out_sr_r, cmd_r;
  logic          load_r, fetch_r, cmd_valid_r, wel_r, cipo_r, cipo_en_r;
  logic [1:0]    id_idx_r;
  logic [7:0]    mem [MemBytes];

  logic          sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s, copi_s;
  logic          byte_done_s, mem_we_s, drive_s;
  logic [7:0]    rx_byte_s, status_s;

  // This function returns one byte of the Read ID sequence. Bytes past the third are zero.
  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = JedecId[23:16];
      2'd1:    b = JedecId[15:8];
      2'd2:    b = JedecId[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // A CS_N rise in the same synchronised cycle masks any SCK edge.
  assign cs_fall_s   = ~cs_sync_r[1] & cs_sync_r[2];
  assign cs_rise_s   = cs_sync_r[1] & ~cs_sync_r[2];
  assign sck_rise_s  = ~cs_sync_r[1] & sck_sync_r[1] & ~sck_sync_r[2];
  assign sck_fall_s  = ~cs_sync_r[1] & ~sck_sync_r[1] & sck_sync_r[2];
  assign copi_s      = copi_sync_r[1];
  assign byte_done_s = sck_rise_s & (bit_cnt_r == 3'd7);
  assign rx_byte_s   = {shift_r, copi_s};
  assign status_s    = {6'b000000, wel_r, 1'b0};
  assign mem_we_s    = byte_done_s & (state_r == PROG);
  assign drive_s     = (state_r == READ) || (state_r == RESP);

  assign spi_cipo_o    = cipo_r;
  assign spi_cipo_en_o = cipo_en_r;
  assign cmd_o         = cmd_r;
  assign cmd_valid_o   = cmd_valid_r;
  assign wel_o         = wel_r;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic: open on CS_N fall, dispatch on opcode, close on CS_N rise.
  always_comb begin
    state_next = state_r;
    if (cs_rise_s) begin
      state_next = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (cs_fall_s) state_next = CMD;
          else           state_next = IDLE;
        end
        CMD: begin
          if (byte_done_s) begin
            case (rx_byte_s)
              8'h03:        state_next = ADDR;
              8'h02:        state_next = wel_r ? ADDR : IGNORE;
              8'h9F, 8'h05: state_next = RESP;
              default:      state_next = IGNORE;
            endcase
          end else begin
            state_next = CMD;
          end
        end
        ADDR: begin
          if (byte_done_s && (addr_cnt_r == 2'd2)) state_next = (cmd_r == 8'h03) ? READ : PROG;
          else                                      state_next = ADDR;
        end
        default: state_next = state_r;
      endcase
    end
  end

  // Synchronisers, the bit/byte datapath, response shifting, the WEL latch and the registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // CS_N sync resets to "selected" so that a release with CS_N low does not look like a fall.
      sck_sync_r  <= 3'b000;
      cs_sync_r   <= 3'b000;
      copi_sync_r <= 2'b00;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 7'd0;
      addr_cnt_r  <= 2'd0;
      addr_r      <= '0;
      ptr_r       <= '0;
      pending_r   <= 8'h00;
      out_sr_r    <= 8'h00;
      load_r      <= 1'b0;
      fetch_r     <= 1'b0;
      id_idx_r    <= 2'd0;
      cmd_r       <= 8'h00;
      cmd_valid_r <= 1'b0;
      wel_r       <= 1'b0;
      wel_act_r   <= WEL_KEEP;
      cipo_r      <= 1'b0;
      cipo_en_r   <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], spi_sck_i};
      cs_sync_r   <= {cs_sync_r[1:0], spi_cs_ni};
      copi_sync_r <= {copi_sync_r[0], spi_copi_i};
      cmd_valid_r <= 1'b0;
      fetch_r     <= 1'b0;
      cipo_en_r   <= drive_s;
      cipo_r      <= drive_s ? out_sr_r[7] : 1'b0;
      if (cs_fall_s) begin
        bit_cnt_r  <= 3'd0;
        shift_r    <= 7'd0;
        addr_cnt_r <= 2'd0;
        out_sr_r   <= 8'h00;
        load_r     <= 1'b0;
        wel_act_r  <= WEL_KEEP;
      end else if (cs_rise_s) begin
        if (wel_act_r == WEL_SET)      wel_r <= 1'b1;
        else if (wel_act_r == WEL_CLR) wel_r <= 1'b0;
        wel_act_r <= WEL_KEEP;
      end else begin
        if (sck_rise_s && (state_r != IDLE)) begin
          bit_cnt_r <= bit_cnt_r + 3'd1;
          shift_r   <= {shift_r[5:0], copi_s};
        end
        if (sck_rise_s && (state_r == ADDR)) begin
          addr_r <= {addr_r[AW-3:0], copi_s};
        end
        if (byte_done_s) begin
          case (state_r)
            CMD: begin
              cmd_r       <= rx_byte_s;
              cmd_valid_r <= 1'b1;
              case (rx_byte_s)
                8'h9F: begin
                  pending_r <= id_byte(2'd0);
                  id_idx_r  <= 2'd1;
                  load_r    <= 1'b1;
                end
                8'h05: begin
                  pending_r <= status_s;
                  load_r    <= 1'b1;
                end
                8'h06:   wel_act_r <= WEL_SET;
                8'h04:   wel_act_r <= WEL_CLR;
                default: wel_act_r <= WEL_KEEP;
              endcase
            end
            ADDR: begin
              addr_cnt_r <= addr_cnt_r + 2'd1;
              if (addr_cnt_r == 2'd2) begin
                ptr_r <= {addr_r, copi_s};
                // Reaching PROG commits the WEL clear even if no data byte follows.
                if (cmd_r == 8'h03) fetch_r   <= 1'b1;
                else                wel_act_r <= WEL_CLR;
              end
            end
            READ: fetch_r <= 1'b1;
            RESP: begin
              if (cmd_r == 8'h9F) begin
                pending_r <= id_byte(id_idx_r);
                if (id_idx_r != 2'd3) id_idx_r <= id_idx_r + 2'd1;
              end else begin
                pending_r <= status_s;
              end
              load_r <= 1'b1;
            end
            PROG:    ptr_r <= ptr_r + PTR_ONE;
            default: load_r <= load_r;
          endcase
        end
        if (fetch_r) begin
          pending_r <= mem[ptr_r];
          ptr_r     <= ptr_r + PTR_ONE;
          load_r    <= 1'b1;
        end
        if (sck_fall_s && drive_s) begin
          if (load_r) begin
            out_sr_r <= pending_r;
            load_r   <= 1'b0;
          end else begin
            out_sr_r <= {out_sr_r[6:0], 1'b0};
          end
        end
      end
    end
  end

  // Page-program write port. The array is intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) mem[ptr_r] <= rx_byte_s;
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: a directed SPI host, a transaction-level flash
// model, and a per-cycle compare thread.
module tb_spi_flash_responder;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       copi = 1'b0;
  logic       cipo, cipo_en, cmd_valid, wel;
  logic [7:0] cmd;

  int         checks = 0;
  int         failures = 0;
  int         vpulses = 0;
  int         p0;
  logic       prev_valid = 1'b0;
  logic       idle_chk = 1'b0;
  logic [7:0] tx [8];
  logic [7:0] rx [8];
  logic [7:0] exp_rx [8];
  logic [7:0] mem_m [256];
  logic       wel_m = 1'b0;
  logic [7:0] cmd_m = 8'h00;
  logic [7:0] r;

  spi_flash_responder #(.MemBytes(256), .JedecId(24'hEF4018)) dut (
    .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_cs_ni(cs_n), .spi_copi_i(copi),
    .spi_cipo_o(cipo), .spi_cipo_en_o(cipo_en), .cmd_o(cmd), .cmd_valid_o(cmd_valid), .wel_o(wel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks = checks + 1;
    if (act !== want) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // One mode-0 bit: set COPI while SCK is low, sample CIPO, then raise SCK.
  task automatic spi_bit(input logic b, output logic rb);
    copi = b;
    repeat (HALF) @(negedge clk);
    rb = cipo;
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] rb);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], t);
      rb[i] = t;
    end
  endtask

  // Flash model: expected response bytes and state updates for one transaction.
  task automatic model_txn(input int n);
    logic [7:0] op;
    logic       w;
    int         a;
    w = wel_m;
    for (int i = 0; i < 8; i++) exp_rx[i] = 8'h00;
    op = tx[0];
    cmd_m = op;
    a = int'(tx[3]);
    for (int i = 1; i < n; i++) begin
      case (op)
        8'h9F: exp_rx[i] = (i == 1) ? 8'hEF : (i == 2) ? 8'h40 : (i == 3) ? 8'h18 : 8'h00;
        8'h05: exp_rx[i] = {6'b000000, w, 1'b0};
        8'h03: if (i >= 4) exp_rx[i] = mem_m[(a + i - 4) % 256];
        8'h02: if ((i >= 4) && w) mem_m[(a + i - 4) % 256] = tx[i];
        default: ;
      endcase
    end
    if (op == 8'h06)                           wel_m = 1'b1;
    else if (op == 8'h04)                      wel_m = 1'b0;
    else if ((op == 8'h02) && w && (n >= 4))   wel_m = 1'b0;
  endtask

  task automatic run_txn(input int n, input int extra, input string nm);
    logic [7:0] rb;
    logic       junk;
    int         q0;
    idle_chk = 1'b0;
    q0 = vpulses;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      send_byte(tx[i], rb);
      rx[i] = rb;
    end
    for (int e = 0; e < extra; e++) spi_bit(tx[n][7 - e], junk);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    model_txn(n);
    for (int i = 0; i < n; i++) chk($sformatf("%s rx[%0d]", nm, i), 32'(rx[i]), 32'(exp_rx[i]));
    chk($sformatf("%s cmd_valid pulses", nm), 32'(vpulses - q0), 32'd1);
    idle_chk = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    // Per-cycle compare thread.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk("cipo quiet while disabled", 32'(cipo & ~cipo_en), 32'd0);
          chk("cmd_valid single cycle", 32'(prev_valid & cmd_valid), 32'd0);
          if (cmd_valid) vpulses = vpulses + 1;
          prev_valid = cmd_valid;
          if (idle_chk) begin
            chk("idle wel", 32'(wel), 32'(wel_m));
            chk("idle cmd", 32'(cmd), 32'(cmd_m));
            chk("idle cipo_en", 32'(cipo_en), 32'd0);
          end
        end else begin
          prev_valid = 1'b0;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset cipo", 32'(cipo), 32'd0);
    chk("reset cipo_en", 32'(cipo_en), 32'd0);
    chk("reset cmd", 32'(cmd), 32'h00);
    chk("reset cmd_valid", 32'(cmd_valid), 32'd0);
    chk("reset wel", 32'(wel), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    idle_chk = 1'b1;

    // Read ID
    tx = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(5, 0, "rdid");
    chk("rdid b1", 32'(rx[1]), 32'hEF);
    chk("rdid b2", 32'(rx[2]), 32'h40);
    chk("rdid b3", 32'(rx[3]), 32'h18);
    chk("rdid b4", 32'(rx[4]), 32'h00);
    chk("rdid cmd", 32'(cmd), 32'h9F);

    // Status / WEL
    tx = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(3, 0, "rdsr0");
    chk("rdsr0 b1", 32'(rx[1]), 32'h00);
    tx = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1, 0, "wren");
    chk("wren wel", 32'(wel), 32'd1);
    tx = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(3, 0, "rdsr1");
    chk("rdsr1 b1", 32'(rx[1]), 32'h02);
    chk("rdsr1 b2 repeat", 32'(rx[2]), 32'h02);
    tx = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1, 0, "wrdi");
    chk("wrdi wel", 32'(wel), 32'd0);
    tx = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(2, 0, "rdsr2");
    chk("rdsr2 b1", 32'(rx[1]), 32'h00);

    // Program with wrap, then read back
    tx = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1, 0, "wren2");
    tx = '{8'h02, 8'h00, 8'h00, 8'hFE, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    run_txn(7, 0, "pp_wrap");
    chk("pp_wrap wel", 32'(wel), 32'd0);
    tx = '{8'h03, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(7, 0, "rd_wrap");
    chk("rd_wrap b0", 32'(rx[4]), 32'hAA);
    chk("rd_wrap b1", 32'(rx[5]), 32'hBB);
    chk("rd_wrap b2", 32'(rx[6]), 32'hCC);
    tx = '{8'h03, 8'h12, 8'h34, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(6, 0, "rd_hiaddr");
    chk("rd_hiaddr b0", 32'(rx[4]), 32'hBB);
    chk("rd_hiaddr b1", 32'(rx[5]), 32'hCC);

    // Protected program leaves old data
    tx = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1, 0, "wren3");
    tx = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h3C, 8'h00, 8'h00, 8'h00};
    run_txn(5, 0, "pp10");
    tx = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h55, 8'h00, 8'h00, 8'h00};
    run_txn(5, 0, "pp10_prot");
    chk("pp10_prot wel", 32'(wel), 32'd0);
    tx = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(5, 0, "rd10");
    chk("rd10 old value", 32'(rx[4]), 32'h3C);

    // Abort mid-byte: only the complete byte is written
    tx = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1, 0, "wren4");
    tx = '{8'h02, 8'h00, 8'h00, 8'h21, 8'h5A, 8'h00, 8'h00, 8'h00};
    run_txn(5, 0, "pp21");
    tx = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1, 0, "wren5");
    tx = '{8'h02, 8'h00, 8'h00, 8'h20, 8'h12, 8'hFF, 8'h00, 8'h00};
    run_txn(5, 5, "pp_abort");
    chk("pp_abort wel", 32'(wel), 32'd0);
    tx = '{8'h03, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(6, 0, "rd_abort");
    chk("rd_abort 0x20", 32'(rx[4]), 32'h12);
    chk("rd_abort 0x21", 32'(rx[5]), 32'h5A);

    // Unknown opcode
    tx = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(2, 0, "unknown");
    chk("unknown cmd", 32'(cmd), 32'hA5);

    // Reset during the second data byte of a read
    tx = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1, 0, "wren6");
    idle_chk = 1'b0;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_byte(8'h03, r);
    send_byte(8'h00, r);
    send_byte(8'h00, r);
    send_byte(8'hFE, r);
    send_byte(8'h00, r);
    chk("rst_rd first byte", 32'(r), 32'hAA);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, copi);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst cipo", 32'(cipo), 32'd0);
    chk("midrst cipo_en", 32'(cipo_en), 32'd0);
    chk("midrst cmd", 32'(cmd), 32'h00);
    chk("midrst cmd_valid", 32'(cmd_valid), 32'd0);
    chk("midrst wel", 32'(wel), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wel_m = 1'b0;
    cmd_m = 8'h00;
    repeat (4) @(negedge clk);
    p0 = vpulses;
    send_byte(8'h9F, r);
    chk("no decode without fresh CS fall", 32'(vpulses - p0), 32'd0);
    chk("no drive without fresh CS fall", 32'(cipo_en), 32'd0);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    idle_chk = 1'b1;
    tx = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(5, 0, "rdid_after_rst");
    chk("rdid_after_rst b1", 32'(rx[1]), 32'hEF);
    chk("rdid_after_rst b3", 32'(rx[3]), 32'h18);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesisable SPI-target (responder) model of a small serial NOR flash, forming the peripheral end of the SPI host links that drive the flash and similar devices. It oversamples a mode-0 SPI bus on the system clock, decodes a subset of the standard flash command set, and serves reads from, and accepts page programs into, an internal byte array. It lets FPGA and simulation builds exercise the SPI host and its driver software end to end without a DPI model.

## Interface
- MemBytes, 256: size of the internal byte array; must be a power of two, minimum 16.
- JedecId, 24'hEF4018: three bytes returned by the Read ID command, MSB first.
- clk_i  input  1  system clock; its frequency must be at least 8x the SCK frequency.
- rst_i  input  1  reset, asynchronous, active-high.
- spi_sck_i  input  1  SPI clock from the host (mode 0); asynchronous to clk_i.
- spi_cs_ni  input  1  chip select, active-low, asynchronous.
- spi_copi_i  input  1  host-to-responder data.
- spi_cipo_o  output  1  responder-to-host data.
- spi_cipo_en_o  output  1  CIPO driver enable; high only while response bits are shifted.
- cmd_o  output  8  opcode of the most recent transaction.
- cmd_valid_o  output  1  one-cycle pulse when an opcode byte completes.
- wel_o  output  1  write-enable latch.

## Operation
- Input conditioning:
  - SCK, CS_N and COPI pass through two-flop synchronisers.
  - A third flop on SCK and CS_N provides edge detection.
  - COPI is sampled on the detected SCK rise.
  - CIPO advances on the detected SCK fall.
- Bit counter (3 bits) and shift register are cleared on every CS_N fall. Bytes assemble MSB first.
- FSM states: IDLE, CMD, ADDR, READ, PROG, RESP, IGNORE.
  - IDLE -> CMD on CS_N fall.
  - CMD, on 8th bit: latch cmd_o, pulse cmd_valid_o, then dispatch:
    - 0x03 Read -> ADDR.
    - 0x02 Page Program -> ADDR if wel_o=1, else IGNORE.
    - 0x9F Read ID -> RESP, shifting JedecId; after 3 bytes, returns zero bytes.
    - 0x05 Read Status -> RESP, shifting {6'b0, wel_o, 1'b0}; the byte repeats while CS_N stays low.
    - 0x06 Write Enable: sets wel_o at CS_N rise. Stay in IGNORE.
    - 0x04 Write Disable: clears wel_o at CS_N rise. Stay in IGNORE.
    - Any other opcode -> IGNORE.
  - ADDR: shift in 24 address bits; the low log2(MemBytes) bits become the pointer. After the 24th bit, go to READ (0x03) or PROG (0x02).
  - READ: shift out mem[ptr], MSB first. Increment ptr after each byte.
  - PROG: on each completed byte, write mem[ptr] <= byte, then increment ptr.
  - IGNORE: drive nothing until CS_N rises.
  - Any state -> IDLE on CS_N rise.
- Pointer wraps modulo MemBytes, in both READ and PROG.
- CS_N rise mid-byte: the partial byte is discarded. No write occurs; the pointer is unchanged.
- CS_N rise after a 0x02 transaction that reached PROG clears wel_o, even if zero bytes were written.
- The memory array is not reset. Contents after power-up are undefined (zero in simulation).
- spi_cipo_en_o is high in READ and RESP only. spi_cipo_o is 0 whenever the enable is low.

## Timing
- Reset values: spi_cipo_o=0, spi_cipo_en_o=0, cmd_o=8'h00, cmd_valid_o=0, wel_o=0, FSM=IDLE.
- Reset mid-transaction: the FSM returns to IDLE, and the transfer resumes only after a fresh CS_N fall.
- Input-to-edge-detect latency is 3 clk_i cycles. CIPO changes no later than 4 clk_i cycles after SCK falls at the pin.
- First response bit:
  - The MSB is placed on spi_cipo_o within 4 cycles of the SCK fall that ends the last command/address bit.
  - It must be stable before the next SCK rise.
  - This holds for a minimum SCK half-period of 4 clk_i cycles.
- Memory read for READ:
  - The first byte is fetched in the cycle after the 24th address bit is sampled.
  - Each subsequent byte is fetched on its 8th SCK rise of the current byte, before the next falling edge.
- cmd_valid_o pulses exactly one cycle, 1 cycle after the 8th SCK rise is detected.
- wel_o updates 1 cycle after the CS_N rise is detected.
- Simultaneous CS_N rise and SCK edge in the same synchronised cycle: the CS_N rise wins, and the edge is ignored.

## Test plan
- Read ID: 0x9F followed by 4 dummy bytes. Host receives EF 40 18 00, and cmd_o=0x9F.
- Status/WEL sequence:
  - 0x05 returns 0x00.
  - 0x06 sets wel_o=1 at CS_N rise; a following 0x05 returns 0x02.
  - 0x04 clears wel_o; a following 0x05 returns 0x00.
- Program and read back:
  - Send 0x06, then 0x02 at address 0x0000FE with data AA BB CC.
  - Read 0x03 at 0x0000FE for 3 bytes: returns AA BB CC, written at 0xFE, 0xFF, 0x00 (wrap).
  - wel_o=0 afterwards.
- Protected program: 0x02 at address 0x10 with 0x55 while wel_o=0. A later read at 0x10 returns the old value.
- Abort:
  - Send 0x06, then 0x02 at address 0x20 with 0x12, then 5 bits, then CS_N rise.
  - Only mem[0x20]=0x12 is written, and wel_o=0.
- Reset mid-Read: assert rst_i during the second data byte. All outputs return to reset values, and the next 0x9F transaction responds correctly.
